// File: rtl/input_debouncer.sv
// Multi-channel push-button/switch debouncer: 2-FF synchronizer, shared sample-tick
// prescaler and a per-channel qualification FSM with registered level and edge outputs.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// STABLE_LO | accepted level is 0, synchronized input agrees
// WAIT_HI   | input went high, counting ticks before accepting the 1
// STABLE_HI | accepted level is 1, synchronized input agrees
// WAIT_LO   | input went low, counting ticks before accepting the 0
module input_debouncer #(
   parameter int NCH          = 2,
   parameter int TICK_DIV     = 100000,
   parameter int STABLE_TICKS = 10
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [NCH-1:0] btn_in,
   output logic [NCH-1:0] btn_db,
   output logic [NCH-1:0] btn_rise,
   output logic [NCH-1:0] btn_fall,
   output logic           tick
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int CW = $clog2(STABLE_TICKS) + 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_TICKS - 1);

   typedef enum logic [1:0] {
      STABLE_LO = 2'd0,
      WAIT_HI   = 2'd1,
      STABLE_HI = 2'd2,
      WAIT_LO   = 2'd3
   } state_e;

   logic [NCH-1:0] sync1_q, sync2_q;
   logic [PW-1:0]  presc_q, presc_d;
   logic           tick_w;
   state_e         state_q [NCH];
   state_e         state_d [NCH];
   logic [CW-1:0]  cnt_q [NCH];
   logic [CW-1:0]  cnt_d [NCH];
   logic [NCH-1:0] db_q, db_d;
   logic [NCH-1:0] rise_q, rise_d;
   logic [NCH-1:0] fall_q, fall_d;

   assign tick_w  = (presc_q == PRESC_LAST);
   assign presc_d = tick_w ? '0 : presc_q + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
         presc_q <= '0;
         db_q    <= '0;
         rise_q  <= '0;
         fall_q  <= '0;
         for (int i = 0; i < NCH; i++) begin
            state_q[i] <= STABLE_LO;
            cnt_q[i]   <= '0;
         end
      end else begin
         sync1_q <= btn_in;
         sync2_q <= sync1_q;
         presc_q <= presc_d;
         db_q    <= db_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         for (int i = 0; i < NCH; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
      end
   end

   // A reversion to the accepted level wins over a tick arriving on the same clock.
   always_comb begin
      db_d   = db_q;
      rise_d = '0;
      fall_d = '0;
      for (int i = 0; i < NCH; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         case (state_q[i])
            STABLE_LO: begin
               if (sync2_q[i]) begin
                  state_d[i] = WAIT_HI;
                  cnt_d[i]   = '0;
               end
            end
            WAIT_HI: begin
               if (!sync2_q[i]) begin
                  state_d[i] = STABLE_LO;
                  cnt_d[i]   = '0;
               end else if (tick_w) begin
                  if (cnt_q[i] == CNT_LAST) begin
                     state_d[i] = STABLE_HI;
                     cnt_d[i]   = '0;
                     db_d[i]    = 1'b1;
                     rise_d[i]  = 1'b1;
                  end else begin
                     cnt_d[i] = cnt_q[i] + 1'b1;
                  end
               end
            end
            STABLE_HI: begin
               if (!sync2_q[i]) begin
                  state_d[i] = WAIT_LO;
                  cnt_d[i]   = '0;
               end
            end
            WAIT_LO: begin
               if (sync2_q[i]) begin
                  state_d[i] = STABLE_HI;
                  cnt_d[i]   = '0;
               end else if (tick_w) begin
                  if (cnt_q[i] == CNT_LAST) begin
                     state_d[i] = STABLE_LO;
                     cnt_d[i]   = '0;
                     db_d[i]    = 1'b0;
                     fall_d[i]  = 1'b1;
                  end else begin
                     cnt_d[i] = cnt_q[i] + 1'b1;
                  end
               end
            end
            default: begin
               state_d[i] = STABLE_LO;
               cnt_d[i]   = '0;
            end
         endcase
      end
   end

   assign btn_db   = db_q;
   assign btn_rise = rise_q;
   assign btn_fall = fall_q;
   assign tick     = tick_w;

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: a deadline-based reference model fills an expectation
// queue every clock, a negedge monitor pops and compares, directed scenarios add checks.
module tb_input_debouncer;

   localparam int D  = 4;
   localparam int ST = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] btn_in;
   logic [1:0] btn_db, btn_rise, btn_fall;
   logic       tick;

   int total = 0;
   int bad   = 0;

   input_debouncer #(.NCH(2), .TICK_DIV(D), .STABLE_TICKS(ST)) dut (
      .clk      (clk),
      .rst      (rst),
      .btn_in   (btn_in),
      .btn_db   (btn_db),
      .btn_rise (btn_rise),
      .btn_fall (btn_fall),
      .tick     (tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
      end
   endtask

   typedef struct packed {
      logic [1:0] db;
      logic [1:0] rise;
      logic [1:0] fall;
      logic       tick;
   } exp_t;

   exp_t exp_q[$];

   // Reference model: a change seen on the synchronized input arms a deadline at the
   // STABLE_TICKS-th tick strictly after entry; any reversion before it cancels.
   int         edge_n  = 0;
   int         r_edge  = 0;
   bit         m_valid = 1'b0;
   logic [1:0] m_db    = 2'b00;
   logic [1:0] h1      = 2'b00;
   logic [1:0] h2      = 2'b00;
   logic [1:0] pend    = 2'b00;
   int         deadline [2];

   always @(posedge clk) begin
      exp_t       e;
      logic [1:0] s;
      edge_n++;
      e.rise = 2'b00;
      e.fall = 2'b00;
      if (rst) begin
         r_edge  = edge_n;
         h1      = 2'b00;
         h2      = 2'b00;
         m_db    = 2'b00;
         pend    = 2'b00;
         m_valid = 1'b1;
      end else begin
         s = h2;
         for (int ch = 0; ch < 2; ch++) begin
            if (pend[ch]) begin
               if (s[ch] == m_db[ch]) begin
                  pend[ch] = 1'b0;
               end else if (edge_n == deadline[ch]) begin
                  pend[ch] = 1'b0;
                  m_db[ch] = s[ch];
                  if (s[ch]) e.rise[ch] = 1'b1;
                  else       e.fall[ch] = 1'b1;
               end
            end else if (s[ch] != m_db[ch]) begin
               pend[ch]     = 1'b1;
               deadline[ch] = r_edge + D * ((edge_n - r_edge) / D + ST);
            end
         end
         h2 = h1;
         h1 = btn_in;
      end
      e.db   = m_db;
      e.tick = ((edge_n + 1 - r_edge) % D == 0);
      if (m_valid) exp_q.push_back(e);
   end

   int rise_cnt [2] = '{0, 0};
   int fall_cnt [2] = '{0, 0};

   always @(negedge clk) begin
      exp_t e;
      for (int ch = 0; ch < 2; ch++) begin
         if (btn_rise[ch] === 1'b1) rise_cnt[ch]++;
         if (btn_fall[ch] === 1'b1) fall_cnt[ch]++;
      end
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("db",   int'(btn_db),   int'(e.db));
         chk("rise", int'(btn_rise), int'(e.rise));
         chk("fall", int'(btn_fall), int'(e.fall));
         chk("tick", int'(tick),     int'(e.tick));
         chk("rise_fall_excl", int'(btn_rise & btn_fall), 0);
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int r0 [2];
      int f0 [2];
      int n;
      int tcount;
      int badgap;
      int last;
      int hold [2];

      // T1: reset with both inputs high, then both accepted together
      rst    = 1'b1;
      btn_in = 2'b11;
      step(5);
      chk("t1_db_in_reset",   int'(btn_db),   0);
      chk("t1_rise_in_reset", int'(btn_rise), 0);
      r0 = rise_cnt;
      rst = 1'b0;
      n = 0;
      while (btn_db != 2'b11 && n < 16) begin
         step(1);
         n++;
      end
      chk("t1_db_accepted", int'(btn_db), 3);
      step(4);
      chk("t1_rise0_count", rise_cnt[0] - r0[0], 1);
      chk("t1_rise1_count", rise_cnt[1] - r0[1], 1);

      // T2: 3-clk glitch is rejected
      btn_in = 2'b00;
      step(20);
      chk("t2_idle_db", int'(btn_db), 0);
      r0 = rise_cnt;
      btn_in = 2'b01;
      step(3);
      btn_in = 2'b00;
      step(20);
      chk("t2_glitch_db", int'(btn_db), 0);
      chk("t2_glitch_rise", rise_cnt[0] - r0[0], 0);

      // T3: bouncing press yields one clean rise
      r0 = rise_cnt;
      f0 = fall_cnt;
      for (int k = 0; k < 10; k++) begin
         btn_in = (k % 2 == 0) ? 2'b01 : 2'b00;
         step(3);
      end
      btn_in = 2'b01;
      n = 0;
      while (btn_db[0] != 1'b1 && n < 16) begin
         step(1);
         n++;
      end
      chk("t3_db_accepted", int'(btn_db), 1);
      step(20);
      chk("t3_rise_count", rise_cnt[0] - r0[0], 1);
      chk("t3_fall_count", fall_cnt[0] - f0[0], 0);
      chk("t3_db_held", int'(btn_db), 1);

      // T4: release on channel 0 only
      f0 = fall_cnt;
      btn_in = 2'b00;
      n = 0;
      while (btn_db[0] != 1'b0 && n < 16) begin
         step(1);
         n++;
      end
      chk("t4_db_released", int'(btn_db), 0);
      step(4);
      chk("t4_fall0_count", fall_cnt[0] - f0[0], 1);
      chk("t4_fall1_count", fall_cnt[1] - f0[1], 0);

      // T5: reset in the middle of a qualification restarts it from scratch
      btn_in = 2'b01;
      step(8);
      rst = 1'b1;
      step(1);
      chk("t5_db_after_reset", int'(btn_db), 0);
      rst = 1'b0;
      n = 0;
      while (btn_db[0] != 1'b1 && n < 30) begin
         step(1);
         n++;
      end
      chk("t5_requalify_latency_ok", int'(n >= 11 && n <= 16), 1);
      chk("t5_db_final", int'(btn_db), 1);

      // T6: tick period and width
      tcount = 0;
      badgap = 0;
      last   = -1;
      for (int i = 0; i < 40; i++) begin
         if (tick) begin
            if (last >= 0 && i - last != D) badgap++;
            last = i;
            tcount++;
         end
         step(1);
      end
      chk("t6_tick_count", tcount, 10);
      chk("t6_tick_gaps", badgap, 0);

      // Random levels with random hold times and occasional resets
      hold[0] = 0;
      hold[1] = 0;
      for (int c = 0; c < 1500; c++) begin
         for (int ch = 0; ch < 2; ch++) begin
            if (hold[ch] == 0) begin
               btn_in[ch] = 1'($urandom_range(0, 1));
               hold[ch]   = $urandom_range(1, 20);
            end
            hold[ch]--;
         end
         rst = ($urandom_range(0, 99) == 0);
         step(1);
      end
      rst = 1'b0;
      step(20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
